note_player: RTL and testbench

- Sits directly downstream of the note-to-step lookup stage.
- Accepts one note and its duration from the song sequencer, and presents that note number to the lookup.
- Accumulates the returned step size into a phase register and reads a quarter-wave sine ROM to produce one signed sample per codec request.
- Counts beats and pulses done_with_note when the note's duration expires.

---
 rtl/note_player.sv | 142 ++++++++++++++
 tb/tb_note_player.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Note player: phase accumulator plus quarter-wave sine ROM sequencing, beat-timed note length.
// Optional half-amplitude release on the last beat when NOTE_RELEASE_EN is defined.
module note_player #(
    parameter int PHASE_W = 20,
    parameter int DUR_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic               load_new_note,
    input  logic [5:0]         note_in,
    input  logic [DUR_W-1:0]   duration_in,
    output logic [5:0]         note_to_lookup,
    input  logic [PHASE_W-1:0] step_size,
    input  logic               beat,
    input  logic               generate_next_sample,
    output logic [7:0]         rom_addr,
    input  logic [15:0]        rom_data,
    output logic [15:0]        sample_out,
    output logic               new_sample_ready,
    output logic               done_with_note
);

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [DUR_W-1:0]   dur;
    logic [1:0]         fetch_q;
    logic               fetch_rest;

    logic [1:0]         quad;
    logic [7:0]         idx;
    logic [7:0]         addr_next;
    logic [DUR_W-1:0]   dur_next;
    logic signed [15:0] mag;
    logic signed [15:0] sample_next;

    // Odd quadrants run the quarter-wave table backwards.
    always_comb begin
        quad      = phase[PHASE_W-1 -: 2];
        idx       = phase[PHASE_W-3 -: 8];
        addr_next = quad[0] ? ~idx : idx;
    end

    always_comb begin
        dur_next = dur;
        if (beat && play_enable && (dur != '0)) begin
            dur_next = dur - DUR_W'(1);
        end
    end

    // Lower half of the wave (q2/q3) is the negated ROM word.
    always_comb begin
        mag         = $signed(rom_data);
        sample_next = fetch_q[1] ? -mag : mag;
`ifdef NOTE_RELEASE_EN
        if (dur == DUR_W'(1)) begin
            sample_next = sample_next >>> 1;
        end
`endif
        if (fetch_rest) begin
            sample_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            phase            <= '0;
            dur              <= '0;
            note_to_lookup   <= '0;
            rom_addr         <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            done_with_note   <= 1'b0;
            fetch_q          <= '0;
            fetch_rest       <= 1'b0;
        end else begin
            new_sample_ready <= 1'b0;
            done_with_note   <= 1'b0;
            if (load_new_note) begin
                // A fetch in flight is simply dropped here.
                note_to_lookup <= note_in;
                dur            <= duration_in;
                phase          <= '0;
                state          <= PLAY;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    PLAY: begin
                        if (play_enable) begin
                            if (dur == '0) begin
                                state          <= DONE;
                                done_with_note <= 1'b1;
                            end else begin
                                dur <= dur_next;
                                if (generate_next_sample) begin
                                    if (note_to_lookup != '0) begin
                                        rom_addr   <= addr_next;
                                        fetch_q    <= quad;
                                        fetch_rest <= 1'b0;
                                        phase      <= phase + step_size;
                                        state      <= ADDR;
                                    end else begin
                                        fetch_rest <= 1'b1;
                                        state      <= DATA;
                                    end
                                end
                            end
                        end
                    end
                    ADDR: begin
                        dur   <= dur_next;
                        state <= DATA;
                    end
                    DATA: begin
                        dur              <= dur_next;
                        sample_out       <= sample_next;
                        new_sample_ready <= 1'b1;
                        state            <= PLAY;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a synchronous ROM model (data = addr*128).
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic        load_new_note;
    logic [5:0]  note_in;
    logic [5:0]  duration_in;
    logic [5:0]  note_to_lookup;
    logic [19:0] step_size;
    logic        beat;
    logic        generate_next_sample;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic        done_with_note;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= {1'b0, rom_addr, 7'b0};

    note_player #(.PHASE_W(20), .DUR_W(6)) dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .load_new_note        (load_new_note),
        .note_in              (note_in),
        .duration_in          (duration_in),
        .note_to_lookup       (note_to_lookup),
        .step_size            (step_size),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .done_with_note       (done_with_note)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] n, input logic [5:0] d);
        note_in       = n;
        duration_in   = d;
        load_new_note = 1'b1;
        tick();
        load_new_note = 1'b0;
        check("load_note", 32'(note_to_lookup), 32'(n));
    endtask

    task automatic req(input logic [7:0] a, input logic [15:0] s);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        check("rom_addr", 32'(rom_addr), 32'(a));
        check("rdy_n0", 32'(new_sample_ready), 32'd0);
        tick();
        check("rdy_n1", 32'(new_sample_ready), 32'd0);
        tick();
        check("rdy_n2", 32'(new_sample_ready), 32'd1);
        check("sample", 32'(sample_out), 32'(s));
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        play_enable = 1'b0;
        load_new_note = 1'b0;
        note_in = '0;
        duration_in = '0;
        step_size = '0;
        beat = 1'b0;
        generate_next_sample = 1'b0;
        tick();
        tick();
        check("rst_note", 32'(note_to_lookup), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_rdy", 32'(new_sample_ready), 32'd0);
        check("rst_done", 32'(done_with_note), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        play_enable = 1'b1;

        // note 4, three beats, step one ROM entry per sample
        step_size = 20'h00400;
        load(6'd4, 6'd3);
        req(8'd0, 16'd0);
        tick();
        check("rdy_pulse", 32'(new_sample_ready), 32'd0);
        req(8'd1, 16'd128);
        req(8'd2, 16'd256);

        // quadrant walk and phase wrap
        step_size = 20'h3FC00;
        req(8'd3, 16'd384);
        req(8'hFD, 16'h7E80);
        req(8'h01, 16'hFF80);
        req(8'hFF, 16'h8080);
        req(8'h00, 16'h0000);
        req(8'hFE, 16'h7F00);

        pulse_beat();
        pulse_beat();
        pulse_beat();
        check("done_early", 32'(done_with_note), 32'd0);
        tick();
        check("done_pulse", 32'(done_with_note), 32'd1);
        tick();
        check("done_end", 32'(done_with_note), 32'd0);

        // rest note
        load(6'd0, 6'd2);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        check("rest_rdy0", 32'(new_sample_ready), 32'd0);
        tick();
        check("rest_rdy1", 32'(new_sample_ready), 32'd1);
        check("rest_sample", 32'(sample_out), 32'd0);
        check("rest_addr", 32'(rom_addr), 32'hFE);
        pulse_beat();
        check("rest_done0", 32'(done_with_note), 32'd0);
        pulse_beat();
        check("rest_done1", 32'(done_with_note), 32'd0);
        tick();
        check("rest_done2", 32'(done_with_note), 32'd1);
        tick();
        check("rest_done3", 32'(done_with_note), 32'd0);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        tick();
        tick();
        check("idle_drop", 32'(new_sample_ready), 32'd0);

        // load during ADDR abandons the fetch
        step_size = 20'h00400;
        load(6'd7, 6'd2);
        req(8'd0, 16'd0);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        check("abort_addr", 32'(rom_addr), 32'd1);
        load(6'd9, 6'd1);
        check("abort_rdy0", 32'(new_sample_ready), 32'd0);
        tick();
        check("abort_rdy1", 32'(new_sample_ready), 32'd0);
        tick();
        check("abort_rdy2", 32'(new_sample_ready), 32'd0);
        req(8'd0, 16'd0);

        // pause: beats and requests ignored
        play_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat = 1'b1;
            generate_next_sample = (i < 3);
            tick();
            beat = 1'b0;
            generate_next_sample = 1'b0;
            tick();
            check("pause_rdy", 32'(new_sample_ready), 32'd0);
            check("pause_done", 32'(done_with_note), 32'd0);
        end
        play_enable = 1'b1;
`ifdef NOTE_RELEASE_EN
        req(8'd1, 16'd64);
        req(8'd2, 16'd128);
`else
        req(8'd1, 16'd128);
        req(8'd2, 16'd256);
`endif
        pulse_beat();
        check("last_done0", 32'(done_with_note), 32'd0);
        tick();
        check("last_done1", 32'(done_with_note), 32'd1);

        // async reset mid-fetch
        load(6'd5, 6'd3);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_sample", 32'(sample_out), 32'd0);
        check("arst_rdy", 32'(new_sample_ready), 32'd0);
        check("arst_note", 32'(note_to_lookup), 32'd0);
        tick();
        reset = 1'b0;
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        tick();
        check("post_rst0", 32'(new_sample_ready), 32'd0);
        tick();
        check("post_rst1", 32'(new_sample_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
